// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared FSM state type and default operand width for the multiplier and reducer.
package seq_mult_pkg;

    localparam int MULT_WIDTH_DEFAULT = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_wide_multiplier.sv
// rtl/seq_wide_multiplier.sv - shift-and-add width x width -> 2*width multiplier, one multiplier bit per cycle.
// Optional SEQ_MULT_EARLY_EXIT_EN: leave RUN as soon as the remaining multiplier bits are all zero.
module seq_wide_multiplier
    import seq_mult_pkg::*;
#(
    parameter int width = MULT_WIDTH_DEFAULT,
    parameter int CNT_W = $clog2(width) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [width-1:0]     x,
    input  logic [width-1:0]     y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*width-1:0]   product,
    output logic                 busy
);

    state_t               state;
    logic [2*width-1:0]   acc;
    logic [2*width-1:0]   mcand;
    logic [width-1:0]     mplier;
    logic [CNT_W-1:0]     cnt;

    logic [2*width-1:0]   acc_sum;
    logic [width-1:0]     mplier_next;
    logic                 last_iter;

    // The final product is < 2^(2*width), so this sum never overflows.
    assign acc_sum     = mplier[0] ? (acc + mcand) : acc;
    assign mplier_next = mplier >> 1;

`ifdef SEQ_MULT_EARLY_EXIT_EN
    assign last_iter = (cnt == CNT_W'(width - 1)) || (mplier_next == '0);
`else
    assign last_iter = (cnt == CNT_W'(width - 1));
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{width{1'b0}}, x};
                        mplier <= y;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier_next;
                    cnt    <= cnt + 1'b1;
                    if (last_iter) begin
                        product <= acc_sum;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_wide_multiplier.sv
// tb/tb_seq_wide_multiplier.sv - scoreboard bench: directed width=8 cases plus random width=128 stream.
module tb_seq_wide_multiplier;

    localparam int NR = 300;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  x8, y8;
    logic [15:0] product8;

    logic         in_valid128, in_ready128, out_valid128, out_ready128, busy128;
    logic [127:0] x128, y128;
    logic [255:0] product128;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0]  q8[$];
    logic [255:0] q128[$];

    logic [127:0] ra, rb;
    int dn, got, cyc;

    seq_wide_multiplier #(.width(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8), .x(x8), .y(y8),
        .out_valid(out_valid8), .out_ready(out_ready8), .product(product8), .busy(busy8)
    );

    seq_wide_multiplier #(.width(128)) dut128 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid128), .in_ready(in_ready128), .x(x128), .y(y128),
        .out_valid(out_valid128), .out_ready(out_ready128), .product(product128), .busy(busy128)
    );

    task automatic check(input string tag, input logic [255:0] got_v, input logic [255:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    function automatic int run_cycles8(input logic [7:0] b);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        int m = 1;
        for (int i = 0; i < 8; i++) if (b[i]) m = i + 1;
        return m;
`else
        return 8;
`endif
    endfunction

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input int hold, input bit poke);
        int n;
        logic [15:0] held;
        logic [15:0] e;
        @(negedge clk);
        check("in_ready_idle", in_ready8, 1'b1);
        x8 = a; y8 = b; in_valid8 = 1'b1;
        q8.push_back(16'(a) * 16'(b));
        @(negedge clk);
        n = 1;
        in_valid8 = poke; x8 = 8'h5a; y8 = 8'hc3;
        while (!out_valid8 && n < 40) begin
            check("in_ready_run", in_ready8, 1'b0);
            check("busy_run", busy8, 1'b1);
            @(negedge clk);
            n++;
        end
        check("latency", n, run_cycles8(b) + 1);
        held = product8;
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", out_valid8, 1'b1);
            check("hold_product", product8, held);
            check("hold_in_ready", in_ready8, 1'b0);
            @(negedge clk);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        check("out_valid", out_valid8, 1'b1);
        e = q8.pop_front();
        check("product8", product8, e);
        @(negedge clk);
        out_ready8 = 1'b0;
        check("in_ready_after", in_ready8, 1'b1);
        check("out_valid_after", out_valid8, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b0; x8 = '0; y8 = '0;
        in_valid128 = 1'b0; out_ready128 = 1'b0; x128 = '0; y128 = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready8, 1'b1);
        check("rst_out_valid", out_valid8, 1'b0);
        check("rst_busy", busy8, 1'b0);
        check("rst_product", product8, 16'h0);
        check("rst_in_ready128", in_ready128, 1'b1);
        reset = 1'b0;

        op8(8'd13, 8'd11, 0, 1'b0);
        op8(8'hff, 8'hff, 0, 1'b0);
        op8(8'h00, 8'haa, 0, 1'b0);
        op8(8'd7, 8'd6, 5, 1'b1);

        // abort on the 4th RUN cycle
        @(negedge clk);
        x8 = 8'd9; y8 = 8'd7; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_abort_busy", busy8, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_in_ready", in_ready8, 1'b1);
        check("abort_out_valid", out_valid8, 1'b0);
        check("abort_busy", busy8, 1'b0);
        check("abort_product", product8, 16'h0);
        repeat (12) begin
            @(negedge clk);
            check("abort_no_valid", out_valid8, 1'b0);
        end

        op8(8'd3, 8'd5, 0, 1'b0);
        op8(8'd200, 8'd1, 0, 1'b0);
        op8(8'd2, 8'h80, 0, 1'b0);

        got = 0;
        fork
            begin
                for (int i = 0; i < NR; i++) begin
                    ra = {$urandom(), $urandom(), $urandom(), $urandom()};
                    rb = {$urandom(), $urandom(), $urandom(), $urandom()};
                    if (i == 0) begin ra = '1; rb = '1; end
                    if (i == 1) rb = '0;
                    if (i == 2) ra = '0;
                    @(negedge clk);
                    x128 = ra; y128 = rb; in_valid128 = 1'b1;
                    dn = 0;
                    while (!in_ready128 && dn < 1000) begin
                        @(negedge clk);
                        dn++;
                    end
                    if (dn >= 1000) check("drv_timeout", 1'b0, 1'b1);
                    q128.push_back({128'b0, ra} * {128'b0, rb});
                    @(posedge clk);
                    #1 in_valid128 = 1'b0;
                end
            end
            begin
                cyc = 0;
                while (got < NR && cyc < NR * 200) begin
                    @(negedge clk);
                    cyc++;
                    out_ready128 = 1'($urandom_range(0, 1));
                    if (out_valid128 && out_ready128) begin
                        if (q128.size() == 0) check("unexpected_product", 1'b1, 1'b0);
                        else check("product128", product128, q128.pop_front());
                        got++;
                    end
                end
                check("rx_count", got, NR);
            end
        join
        out_ready128 = 1'b0;
        check("queue_empty", q128.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
